// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder/subtractor.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_e;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

   // True when a nibble is a legal decimal digit.
   function automatic logic digit_valid(input logic [3:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder cell: binary add plus decimal correction.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  logic [3:0] x_i,
   input  logic [3:0] y_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [4:0] bin_sum;

   // Binary sum of the two digits, corrected by +6 when it exceeds nine.
   always_comb begin
      bin_sum = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, cin_i};
      if (bin_sum > {1'b0, BCD_MAX}) begin
         sum_o  = bin_sum[3:0] + BCD_CORR;
         cout_o = 1'b1;
      end else begin
         sum_o  = bin_sum[3:0];
         cout_o = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor with sign-magnitude result and
// start/ready/done handshake; one shared digit cell serves RUN and FIX.
module bcd_addsub_serial
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  neg,
   output logic                  err
);

   localparam int unsigned   IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   state_e               state_q;
   logic [IW-1:0]        idx_q;
   logic [4*DIGITS-1:0]  a_q;
   logic [4*DIGITS-1:0]  b_q;
   logic [4*DIGITS-1:0]  result_q;
   logic                 sub_q;
   logic                 carry_q;
   logic                 ready_q;
   logic                 done_q;
   logic                 cout_q;
   logic                 neg_q;
   logic                 err_q;

   logic                 ops_ok;
   logic [3:0]           add_x;
   logic [3:0]           add_y;
   logic [3:0]           dsum;
   logic                 dcarry;

   // Every nibble of both latched operands must be a decimal digit.
   always_comb begin
      ops_ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!digit_valid(a_q[4*i +: 4]) || !digit_valid(b_q[4*i +: 4])) begin
            ops_ok = 1'b0;
         end
      end
   end

   // Operand mux: A with B or its 9's complement in RUN, 9's complement of
   // the partial result in FIX (ten's-complement negation with carry-in 1).
   always_comb begin
      if (state_q == FIX) begin
         add_x = BCD_MAX - result_q[4*idx_q +: 4];
         add_y = 4'd0;
      end else begin
         add_x = a_q[4*idx_q +: 4];
         add_y = sub_q ? (BCD_MAX - b_q[4*idx_q +: 4]) : b_q[4*idx_q +: 4];
      end
   end

   bcd_digit_adder u_digit (
      .x_i    (add_x),
      .y_i    (add_y),
      .cin_i  (carry_q),
      .sum_o  (dsum),
      .cout_o (dcarry)
   );

   // Control FSM, digit sequencing and all output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (ready_q && start) begin
            a_q      <= a;
            b_q      <= b;
            sub_q    <= sub;
            idx_q    <= '0;
            carry_q  <= sub;
            result_q <= '0;
            cout_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= RUN;
         end else begin
            unique case (state_q)
               IDLE: ;
               RUN: begin
                  // Operand validity is judged on the latched copy in the
                  // first RUN cycle, so an error completes one edge after accept.
                  if ((idx_q == '0) && !ops_ok) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     ready_q  <= 1'b1;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     result_q[4*idx_q +: 4] <= dsum;
                     carry_q                <= dcarry;
                     if (idx_q == LAST) begin
                        if (!sub_q || dcarry) begin
                           cout_q  <= sub_q ? 1'b0 : dcarry;
                           ready_q <= 1'b1;
                           done_q  <= 1'b1;
                           state_q <= DONE;
                        end else begin
                           idx_q   <= '0;
                           carry_q <= 1'b1;
                           state_q <= FIX;
                        end
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end
               end
               FIX: begin
                  result_q[4*idx_q +: 4] <= dsum;
                  carry_q                <= dcarry;
                  if (idx_q == LAST) begin
                     neg_q   <= 1'b1;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
               DONE: state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ready  = ready_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock through a single shared digit-adder cell. It is the sequential successor to the lab's single-digit combinational BCD adder. It adds arbitrary width, subtraction with sign-magnitude output, input validity checking and a start/ready/done handshake. It sits between operand registers and a display or accumulator stage in the lab designs.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand (≥1).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request a new operation; accepted only when `ready`=1.
- `sub` in 1: 0 = A+B, 1 = A−B; sampled with `start`.
- `a` in 4*DIGITS: operand A, digit 0 in bits [3:0].
- `b` in 4*DIGITS: operand B, same packing.
- `ready` out 1: block idle and able to accept `start`.
- `done` out 1: single-cycle pulse when the result is valid.
- `result` out 4*DIGITS: BCD result; for subtraction it is the magnitude.
- `cout` out 1: addition overflow (decimal carry out of the top digit).
- `neg` out 1: subtraction result is negative.
- `err` out 1: an operand contained a nibble >9.

## Operation
- States:
  - IDLE: `ready`=1.
  - RUN: adding, digit index 0..DIGITS−1.
  - FIX: negating a negative subtraction result.
  - DONE: one cycle, `done`=1, then return to IDLE.
- Accept: `start`=1 while `ready`=1 latches `a`, `b` and `sub`, clears the digit index and sets the carry-in to `sub`.
- Validity: any nibble of `a` or `b` >9 at accept goes directly to DONE with `result`=0, `err`=1, `cout`=0, `neg`=0.
- RUN, per cycle:
  - Digit i = A[i] + (sub ? 9−B[i] : B[i]) + carry.
  - If the binary sum is >9, add 6 and set carry=1.
  - Write digit i of `result`, advance the index.
- After digit DIGITS−1:
  - Add mode: `cout`=final carry, `neg`=0, go to DONE.
  - Sub mode with final carry=1: non-negative result, `neg`=0, `cout`=0, go to DONE.
  - Sub mode with final carry=0: the result is the ten's complement. Go to FIX with index cleared and carry-in 1.
- FIX, per cycle: digit i = (9 − R[i]) + carry, with the same correction rule. After the last digit set `neg`=1 and go to DONE.
- Width rule: the top-digit carry is never stored in `result`.
- `result`, `cout`, `neg` and `err` hold from DONE until the next accepted `start`. They are cleared at accept.
- `start` while `ready`=0 is ignored, with no queuing.

## Timing
- Reset value of every output is 0 except `ready`=1. The state is IDLE.
- `rst_n` low mid-operation aborts immediately. No `done` is produced and the latched operands are discarded.
- Let T0 be the accepting clock edge. `ready` falls after T0.
- `done` is high in the cycle following:
  - edge T0+1 on error;
  - edge T0+DIGITS for add or non-negative subtract;
  - edge T0+2*DIGITS for negative subtract.
- `ready` is high again in the same cycle as `done`. A `start` in that cycle is accepted, giving back-to-back operations with no idle gap.
- `result` digits update progressively during RUN/FIX. They are defined only when `done`=1 and afterwards.

## Structure
- Package `bcd_pkg`:
  - state enum (IDLE, RUN, FIX, DONE);
  - `BCD_MAX`=9 and `BCD_CORR`=6;
  - function `digit_valid`.
- Sub-module `bcd_digit_adder`: combinational. Inputs are two 4-bit digits and carry-in; outputs are a corrected 4-bit digit and carry-out. It is instantiated once and shared between RUN and FIX.
- Top level contains the FSM, digit index counter, operand and result registers, and a 9's-complement mux.

## Test plan
All cases use DIGITS=4.
- Add 1234+5678 → `result`=6912, `cout`=0, `neg`=0, `done` after T0+4.
- Add 9999+0001 → `result`=0000, `cout`=1. Add 0000+0000 → 0000, `cout`=0.
- Sub 5000−1234 → `result`=3766, `neg`=0, `done` after T0+4. Sub 0000−0000 → 0000, `neg`=0.
- Sub 0003−0007 → `result`=0004, `neg`=1, `done` after T0+8. Sub 0000−9999 → 9999, `neg`=1.
- `a`=12A4 (nibble A) → `err`=1, `result`=0, `done` after T0+1.
- Protocol, three cases:
  - `start` pulsed at T0+2 while busy is ignored and the first result is unaffected.
  - `start` in the `done` cycle is accepted.
  - `rst_n` low at T0+2 gives `ready`=1 and all other outputs 0, with no `done` pulse.
